// File: rtl/tx_pkg.sv
// Shared constants for the TX frame scheduler: FSM encodings, default
// quantum/timeout values and the quantum normalisation helper.
package tx_pkg;

  // Scheduler FSM encodings (kept as plain constants for legacy tools)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARB   = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  // Defaults for the frames-per-turn quantum and the per-frame watchdog
  localparam logic [3:0] DEF_QUANTUM = 4'd1;
  localparam int         DEF_TMO     = 4096;

  // A programmed quantum of zero would starve the queue; serve one frame
  function automatic logic [3:0] eff_quantum(input logic [3:0] q);
    return (q == 4'd0) ? DEF_QUANTUM : q;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: returns the first set request bit searching
// upward from last_idx+1 (mod N). Purely combinational so both the TX
// scheduler and the RX side can share it.
module rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_idx,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx
);

  logic [W-1:0] cand;
  logic         found;

  // Walk N candidates starting just after the previous winner
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= N; i++) begin
      cand = W'((int'(last_idx) + i) % N);
      if (!found && req[cand]) begin
        onehot[cand] = 1'b1;
        idx          = cand;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_frame_scheduler.sv
// TX frame scheduler: arbitrates NQ transmit ring engines onto one MAC TX
// port. Queues with committed data are served round-robin with a
// per-queue burst quantum; a watchdog recovers from engines that never
// finish a frame.
module tx_frame_scheduler
  import tx_pkg::*;
#(
  parameter int NQ  = 4,
  parameter int AW  = 10,
  parameter int TMO = DEF_TMO
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NQ*AW-1:0]        q_wr_ptr,
  input  logic [NQ*AW-1:0]        q_rd_ptr,
  input  logic [NQ-1:0]           q_enable,
  input  logic [NQ*4-1:0]         q_quantum,
  output logic [NQ-1:0]           grant,
  output logic                    start,
  input  logic                    frame_done,
  output logic [$clog2(NQ)-1:0]   cur_q,
  output logic                    busy,
  output logic                    tmo_err,
  input  logic                    tmo_clr,
  output logic [31:0]             frames_sent
);

  localparam int QW  = $clog2(NQ);
  localparam int WDW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TMO - 1);

  logic [2:0]     state;
  logic [NQ-1:0]  req;
  logic [NQ-1:0]  req_nxt;
  logic [3:0]     burst_cnt;
  logic [WDW-1:0] wd_cnt;
  logic           gap_cnt;
  logic [QW-1:0]  last_q;
  logic [NQ-1:0]  pick_oh;
  logic [QW-1:0]  pick_idx;
  logic [3:0]     cur_quantum;

  // A queue requests when enabled and its ring holds at least one qword
  // (pointer difference taken modulo the ring size, so wrap is handled)
  always_comb begin
    req_nxt = '0;
    for (int q = 0; q < NQ; q++) begin
      req_nxt[q] = q_enable[q] &
                   ((q_wr_ptr[q*AW +: AW] - q_rd_ptr[q*AW +: AW]) != '0);
    end
  end

  // Register the request vector; the GAP state covers this one-cycle lag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req <= '0;
    end else begin
      req <= req_nxt;
    end
  end

  // Quantum of the currently granted queue
  always_comb begin
    cur_quantum = DEF_QUANTUM;
    for (int q = 0; q < NQ; q++) begin
      if (cur_q == QW'(q)) begin
        cur_quantum = q_quantum[q*4 +: 4];
      end
    end
  end

  rr_pick #(
    .N (NQ),
    .W (QW)
  ) u_pick (
    .req      (req),
    .last_idx (last_q),
    .onehot   (pick_oh),
    .idx      (pick_idx)
  );

  // Start is only ever high in ISSUE, where grant is already settled and
  // cannot change until the frame has finished
  assign start = (state == ST_ISSUE);
  assign busy  = |grant;

  // Scheduler FSM, grant/burst bookkeeping, watchdog and frame counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      grant       <= '0;
      cur_q       <= '0;
      tmo_err     <= 1'b0;
      frames_sent <= '0;
      burst_cnt   <= '0;
      wd_cnt      <= '0;
      gap_cnt     <= 1'b0;
      last_q      <= QW'(NQ - 1);
    end else begin
      // Clear first so a watchdog expiry later in this block wins
      if (tmo_clr) begin
        tmo_err <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (|req) begin
            state <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (|req) begin
            grant     <= pick_oh;
            cur_q     <= pick_idx;
            burst_cnt <= 4'd1;
            state     <= ST_ISSUE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          wd_cnt <= '0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (frame_done) begin
            frames_sent <= frames_sent + 32'd1;
            gap_cnt     <= 1'b0;
            state       <= ST_GAP;
          end else if (wd_cnt == WD_LAST) begin
            // Engine hung: abandon the frame and move on past this queue
            tmo_err <= 1'b1;
            grant   <= '0;
            last_q  <= cur_q;
            state   <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == 1'b0) begin
            gap_cnt <= 1'b1;
          end else if (req[cur_q] && (burst_cnt < eff_quantum(cur_quantum))) begin
            burst_cnt <= burst_cnt + 4'd1;
            state     <= ST_ISSUE;
          end else begin
            last_q <= cur_q;
            grant  <= '0;
            state  <= ST_ARB;
          end
        end
        default: begin
          grant <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler: bursts, round-robin order,
// pointer wrap, watchdog, mid-frame disable and mid-frame reset.
module tb_tx_frame_scheduler;

  localparam int NQ  = 4;
  localparam int AW  = 10;
  localparam int TMO = 4096;

  logic              clk = 1'b0;
  logic              reset;
  logic [NQ*AW-1:0]  q_wr_ptr;
  logic [NQ*AW-1:0]  q_rd_ptr;
  logic [NQ-1:0]     q_enable;
  logic [NQ*4-1:0]   q_quantum;
  logic [NQ-1:0]     grant;
  logic              start;
  logic              frame_done;
  logic [1:0]        cur_q;
  logic              busy;
  logic              tmo_err;
  logic              tmo_clr;
  logic [31:0]       frames_sent;

  int n_chk  = 0;
  int n_pass = 0;

  tx_frame_scheduler #(
    .NQ  (NQ),
    .AW  (AW),
    .TMO (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .q_wr_ptr    (q_wr_ptr),
    .q_rd_ptr    (q_rd_ptr),
    .q_enable    (q_enable),
    .q_quantum   (q_quantum),
    .grant       (grant),
    .start       (start),
    .frame_done  (frame_done),
    .cur_q       (cur_q),
    .busy        (busy),
    .tmo_err     (tmo_err),
    .tmo_clr     (tmo_clr),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_q(input int q, input logic [AW-1:0] wr, input logic [AW-1:0] rd);
    q_wr_ptr[q*AW +: AW] = wr;
    q_rd_ptr[q*AW +: AW] = rd;
  endtask

  task automatic commit(input int q);
    q_rd_ptr[q*AW +: AW] = q_rd_ptr[q*AW +: AW] + AW'(1);
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    q_wr_ptr   = '0;
    q_rd_ptr   = '0;
    q_enable   = '0;
    q_quantum  = '0;
    frame_done = 1'b0;
    tmo_clr    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called on a negedge; returns on the negedge where start is high
  task automatic wait_start(input string tag);
    int k = 0;
    while (start !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, " start"}, 32'(start), 32'd1);
  endtask

  // Called in the ISSUE cycle; finishes the frame one cycle into WAIT and
  // commits the read pointer like the engine would
  task automatic send_frame(input string tag, input int q);
    @(negedge clk);
    check({tag, " start width"}, 32'(start), 32'd0);
    frame_done = 1'b1;
    commit(q);
    @(negedge clk);
    frame_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    // ---------------- reset values ----------------
    reset = 1'b1; q_wr_ptr = '0; q_rd_ptr = '0; q_enable = '0;
    q_quantum = '0; frame_done = 1'b0; tmo_clr = 1'b0;
    @(negedge clk);
    check("rst grant", 32'(grant), 32'd0);
    check("rst start", 32'(start), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst cur_q", 32'(cur_q), 32'd0);
    check("rst tmo_err", 32'(tmo_err), 32'd0);
    check("rst frames", frames_sent, 32'd0);

    // ---------------- single queue, quantum 2 ----------------
    apply_reset();
    q_enable  = 4'b0001;
    q_quantum = {4'd0, 4'd0, 4'd0, 4'd2};
    set_q(0, 10'd3, 10'd0);
    wait_start("t1 f1");
    check("t1 f1 grant", 32'(grant), 32'b0001);
    check("t1 f1 cur_q", 32'(cur_q), 32'd0);
    send_frame("t1 f1", 0);
    repeat (2) @(negedge clk);
    check("t1 burst start", 32'(start), 32'd1);
    check("t1 burst grant", 32'(grant), 32'b0001);
    send_frame("t1 f2", 0);
    repeat (2) @(negedge clk);
    check("t1 rearb busy", 32'(busy), 32'd0);
    check("t1 rearb start", 32'(start), 32'd0);
    wait_start("t1 f3");
    check("t1 f3 grant", 32'(grant), 32'b0001);
    send_frame("t1 f3", 0);
    check("t1 frames", frames_sent, 32'd3);

    // ---------------- all queues, quantum 1 (q3 programmed 0) ----------------
    apply_reset();
    q_enable  = 4'b1111;
    q_quantum = {4'd0, 4'd1, 4'd1, 4'd1};
    set_q(0, 10'd2, 10'd0);
    set_q(1, 10'd1, 10'd0);
    set_q(2, 10'd1, 10'd0);
    set_q(3, 10'd1, 10'd0);
    for (int i = 0; i < 5; i++) begin
      wait_start($sformatf("t2 turn%0d", i));
      check($sformatf("t2 turn%0d cur_q", i), 32'(cur_q), 32'(i % 4));
      check($sformatf("t2 turn%0d grant", i), 32'(grant), 32'(1 << (i % 4)));
      send_frame($sformatf("t2 turn%0d", i), i % 4);
    end
    check("t2 frames", frames_sent, 32'd5);

    // ---------------- pointer wrap ----------------
    apply_reset();
    q_enable  = 4'b0010;
    q_quantum = {4'd0, 4'd0, 4'd4, 4'd0};
    set_q(1, 10'h3FE, 10'h3FE);
    repeat (6) @(negedge clk);
    check("t3 empty busy", 32'(busy), 32'd0);
    set_q(1, 10'h002, 10'h3FE);
    for (int i = 0; i < 4; i++) begin
      wait_start($sformatf("t3 f%0d", i));
      check($sformatf("t3 f%0d grant", i), 32'(grant), 32'b0010);
      send_frame($sformatf("t3 f%0d", i), 1);
    end
    repeat (8) @(negedge clk);
    check("t3 drained busy", 32'(busy), 32'd0);
    check("t3 frames", frames_sent, 32'd4);

    // ---------------- stray frame_done and watchdog ----------------
    apply_reset();
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    @(negedge clk);
    check("t4 stray done", frames_sent, 32'd0);
    q_enable  = 4'b0011;
    q_quantum = {4'd1, 4'd1, 4'd1, 4'd1};
    set_q(0, 10'd1, 10'd0);
    set_q(1, 10'd1, 10'd0);
    wait_start("t4 q0");
    check("t4 q0 grant", 32'(grant), 32'b0001);
    repeat (TMO) @(negedge clk);
    check("t4 pre tmo_err", 32'(tmo_err), 32'd0);
    check("t4 pre grant", 32'(grant), 32'b0001);
    tmo_clr = 1'b1;
    @(negedge clk);
    check("t4 tmo_err set wins", 32'(tmo_err), 32'd1);
    check("t4 tmo grant", 32'(grant), 32'd0);
    @(negedge clk);
    tmo_clr = 1'b0;
    check("t4 tmo_clr", 32'(tmo_err), 32'd0);
    wait_start("t4 after tmo");
    check("t4 next cur_q", 32'(cur_q), 32'd1);
    check("t4 next grant", 32'(grant), 32'b0010);
    check("t4 frames", frames_sent, 32'd0);

    // ---------------- enable dropped mid-frame ----------------
    apply_reset();
    q_enable  = 4'b1100;
    q_quantum = {4'd2, 4'd2, 4'd0, 4'd0};
    set_q(2, 10'd2, 10'd0);
    set_q(3, 10'd2, 10'd0);
    wait_start("t5 q2");
    check("t5 q2 grant", 32'(grant), 32'b0100);
    @(negedge clk);
    q_enable = 4'b1000;
    @(negedge clk);
    check("t5 held grant", 32'(grant), 32'b0100);
    frame_done = 1'b1;
    commit(2);
    @(negedge clk);
    frame_done = 1'b0;
    check("t5 frames", frames_sent, 32'd1);
    wait_start("t5 q3");
    check("t5 q3 grant", 32'(grant), 32'b1000);
    check("t5 q3 cur_q", 32'(cur_q), 32'd3);

    // ---------------- reset during WAIT ----------------
    apply_reset();
    q_enable  = 4'b0010;
    q_quantum = {4'd1, 4'd1, 4'd1, 4'd1};
    set_q(1, 10'd2, 10'd0);
    wait_start("t6 f1");
    send_frame("t6 f1", 1);
    wait_start("t6 f2");
    check("t6 f2 grant", 32'(grant), 32'b0010);
    @(negedge clk);
    q_enable = 4'b1011;
    set_q(0, 10'd1, 10'd0);
    set_q(3, 10'd1, 10'd0);
    #2 reset = 1'b1;
    #1;
    check("t6 rst grant", 32'(grant), 32'd0);
    check("t6 rst start", 32'(start), 32'd0);
    check("t6 rst busy", 32'(busy), 32'd0);
    check("t6 rst cur_q", 32'(cur_q), 32'd0);
    check("t6 rst frames", frames_sent, 32'd0);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    wait_start("t6 after rst");
    check("t6 first grant", 32'(grant), 32'b0001);
    check("t6 first cur_q", 32'(cur_q), 32'd0);
    check("t6 frames kept", frames_sent, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
